// File: rtl/quick_spi_slave.sv
// quick_spi responder: oversamples sck/ss_n/mosi in the clk domain, shifts words
// MSB first, and feeds miso from a single valid/ready transmit holding register.
module quick_spi_slave #(
   parameter int   DATA_WIDTH = 8,
   parameter logic CPOL       = 1'b0,
   parameter logic CPHA       = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  sck_i,
   input  logic                  ss_n_i,
   input  logic                  mosi_i,
   output logic                  miso_o,
   output logic                  miso_oe_o,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic [DATA_WIDTH-1:0] data_out_o,
   output logic                  new_data_o,
   output logic                  busy_o,
   output logic                  tx_underrun_o,
   output logic                  frame_err_o
);

   localparam int CntW = $clog2(DATA_WIDTH + 1);
   localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {Idle, Load, Xfer} state_e;

   state_e                state_q, state_d;
   logic [1:0]            sckSync_q;
   logic                  sckPrev_q;
   logic [2:0]            ssSync_q;
   logic [1:0]            mosiSync_q;
   logic [DATA_WIDTH-1:0] shiftRx_q, shiftTx_q, hold_q, dataOut_q;
   logic [CntW-1:0]       bitCnt_q;
   logic                  holdFull_q, miso_q, busy_q, newData_q;
   logic                  underrun_q, underrunPend_q, frameErr_q;

   logic sckS, ssS, ssPrev, mosiS;
   logic sckRise, sckFall, leadEdge, trailEdge;
   logic inXfer, sampleEdge, shiftEdge, shiftOk, wordEnd, ssFall, ssRise;
   logic [DATA_WIDTH-1:0] loadWord;

   // ss_n synchronizer resets low so a select already held at reset release is not seen as a fall
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sckSync_q  <= {2{CPOL}};
         sckPrev_q  <= CPOL;
         ssSync_q   <= '0;
         mosiSync_q <= '0;
      end else begin
         sckSync_q  <= {sckSync_q[0], sck_i};
         sckPrev_q  <= sckSync_q[1];
         ssSync_q   <= {ssSync_q[1:0], ss_n_i};
         mosiSync_q <= {mosiSync_q[0], mosi_i};
      end
   end

   assign sckS       = sckSync_q[1];
   assign ssS        = ssSync_q[1];
   assign ssPrev     = ssSync_q[2];
   assign mosiS      = mosiSync_q[1];
   assign ssFall     = ssPrev & ~ssS;
   assign ssRise     = ~ssPrev & ssS;
   assign sckRise    = sckS & ~sckPrev_q;
   assign sckFall    = ~sckS & sckPrev_q;
   assign leadEdge   = CPOL ? sckFall : sckRise;
   assign trailEdge  = CPOL ? sckRise : sckFall;
   assign inXfer     = (state_q == Xfer) & ~ssS;
   assign sampleEdge = inXfer & (CPHA ? trailEdge : leadEdge);
   assign shiftEdge  = inXfer & (CPHA ? leadEdge : trailEdge);
   // In mode CPHA=0 the MSB is presented by Load, so the trailing edge before any sample is not a shift
   assign shiftOk    = CPHA | (bitCnt_q != '0);
   assign wordEnd    = sampleEdge & (bitCnt_q == LastBit);
   assign loadWord   = holdFull_q ? hold_q : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= Idle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         Idle:    if (ssFall) state_d = Load;
         Load:    state_d = Xfer;
         Xfer:    if (wordEnd) state_d = Load;
         default: state_d = Idle;
      endcase
      if (ssRise) state_d = Idle;
   end

   // Underrun is reported on the first leading edge of a word, so the trailing Load that follows
   // the final word of a frame does not raise a false alarm
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shiftRx_q      <= '0;
         shiftTx_q      <= '0;
         hold_q         <= '0;
         holdFull_q     <= 1'b0;
         dataOut_q      <= '0;
         bitCnt_q       <= '0;
         miso_q         <= 1'b0;
         busy_q         <= 1'b0;
         newData_q      <= 1'b0;
         underrun_q     <= 1'b0;
         underrunPend_q <= 1'b0;
         frameErr_q     <= 1'b0;
      end else begin
         newData_q  <= 1'b0;
         underrun_q <= 1'b0;
         frameErr_q <= 1'b0;
         busy_q     <= (state_d != Idle);

         if (state_q == Load && holdFull_q) begin
            holdFull_q <= 1'b0;
         end else if (tx_valid_i && !holdFull_q) begin
            hold_q     <= tx_data_i;
            holdFull_q <= 1'b1;
         end

         case (state_q)
            Idle: begin
               miso_q         <= 1'b0;
               bitCnt_q       <= '0;
               shiftRx_q      <= '0;
               underrunPend_q <= 1'b0;
            end
            Load: begin
               bitCnt_q       <= '0;
               underrunPend_q <= ~holdFull_q;
               if (CPHA == 1'b0) begin
                  miso_q    <= loadWord[DATA_WIDTH-1];
                  shiftTx_q <= loadWord << 1;
               end else begin
                  shiftTx_q <= loadWord;
               end
            end
            Xfer: begin
               if (sampleEdge) begin
                  shiftRx_q <= {shiftRx_q[DATA_WIDTH-2:0], mosiS};
                  bitCnt_q  <= bitCnt_q + CntW'(1);
               end
               if (wordEnd) begin
                  dataOut_q <= {shiftRx_q[DATA_WIDTH-2:0], mosiS};
                  newData_q <= 1'b1;
               end
               if (shiftEdge && shiftOk) begin
                  miso_q    <= shiftTx_q[DATA_WIDTH-1];
                  shiftTx_q <= shiftTx_q << 1;
               end
               if (inXfer && leadEdge && bitCnt_q == '0 && underrunPend_q) begin
                  underrun_q     <= 1'b1;
                  underrunPend_q <= 1'b0;
               end
               if (ssRise && bitCnt_q != '0) frameErr_q <= 1'b1;
            end
            default: bitCnt_q <= '0;
         endcase
      end
   end

   assign miso_o        = miso_q & busy_q;
   assign miso_oe_o     = busy_q;
   assign busy_o        = busy_q;
   assign tx_ready_o    = ~holdFull_q;
   assign data_out_o    = dataOut_q;
   assign new_data_o    = newData_q;
   assign tx_underrun_o = underrun_q;
   assign frame_err_o   = frameErr_q;

endmodule

// File: tb/tb_quick_spi_slave.sv
// Directed bench for quick_spi_slave: a mode-0 instance and a mode-3 instance driven
// by a behavioural SPI master, with hand-computed expectations checked by assertions.
module tb_quick_spi_slave;

   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       sck0 = 1'b0, ssN0 = 1'b1, mosi0 = 1'b0, txValid0 = 1'b0;
   logic [7:0] txData0 = '0;
   logic       miso0, misoOe0, txReady0, newData0, busy0, underrun0, frameErr0;
   logic [7:0] dataOut0;

   logic       sck3 = 1'b1, ssN3 = 1'b1, mosi3 = 1'b0, txValid3 = 1'b0;
   logic [7:0] txData3 = '0;
   logic       miso3, misoOe3, txReady3, newData3, busy3, underrun3, frameErr3;
   logic [7:0] dataOut3;

   int assertCount = 0;
   int failCount   = 0;
   int ndCnt0 = 0, urCnt0 = 0, feCnt0 = 0;
   int ndCnt3 = 0, urCnt3 = 0, feCnt3 = 0;

   always #5 clk = ~clk;

   quick_spi_slave #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .sck_i(sck0), .ss_n_i(ssN0), .mosi_i(mosi0),
      .miso_o(miso0), .miso_oe_o(misoOe0), .tx_data_i(txData0), .tx_valid_i(txValid0),
      .tx_ready_o(txReady0), .data_out_o(dataOut0), .new_data_o(newData0), .busy_o(busy0),
      .tx_underrun_o(underrun0), .frame_err_o(frameErr0)
   );

   quick_spi_slave #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .sck_i(sck3), .ss_n_i(ssN3), .mosi_i(mosi3),
      .miso_o(miso3), .miso_oe_o(misoOe3), .tx_data_i(txData3), .tx_valid_i(txValid3),
      .tx_ready_o(txReady3), .data_out_o(dataOut3), .new_data_o(newData3), .busy_o(busy3),
      .tx_underrun_o(underrun3), .frame_err_o(frameErr3)
   );

   // Strobe counters, sampled on the falling edge away from the DUT's active edge
   always @(negedge clk) begin
      if (newData0)  ndCnt0++;
      if (underrun0) urCnt0++;
      if (frameErr0) feCnt0++;
      if (newData3)  ndCnt3++;
      if (underrun3) urCnt3++;
      if (frameErr3) feCnt3++;
   end

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic writeTx(input int mode, input logic [7:0] d);
      if (mode == 0) begin txData0 = d; txValid0 = 1'b1; end
      else           begin txData3 = d; txValid3 = 1'b1; end
      waitClk(1);
      txValid0 = 1'b0;
      txValid3 = 1'b0;
   endtask

   // Behavioural master: shifts nBits of mosiByte MSB first, collects miso at its sample edges
   task automatic applyStimulus(input int mode, input logic [7:0] mosiByte, input int nBits,
                                output logic [7:0] misoByte);
      misoByte = '0;
      for (int i = 0; i < nBits; i++) begin
         if (mode == 0) begin
            mosi0 = mosiByte[7-i];
            waitClk(HALF);
            sck0 = 1'b1;
            misoByte = {misoByte[6:0], miso0};
            waitClk(HALF);
            sck0 = 1'b0;
         end else begin
            sck3  = 1'b0;
            mosi3 = mosiByte[7-i];
            waitClk(HALF);
            sck3 = 1'b1;
            misoByte = {misoByte[6:0], miso3};
            waitClk(HALF);
         end
      end
   endtask

   initial begin
      logic [7:0] rx, rxA, rxB;
      int nd, ur, fe;

      // Reset values
      waitClk(3);
      checkOutput("rst_miso",     32'(miso0),     32'h0);
      checkOutput("rst_miso_oe",  32'(misoOe0),   32'h0);
      checkOutput("rst_tx_ready", 32'(txReady0),  32'h1);
      checkOutput("rst_data_out", 32'(dataOut0),  32'h0);
      checkOutput("rst_busy",     32'(busy0),     32'h0);
      checkOutput("rst_new_data", 32'(newData0),  32'h0);
      checkOutput("rst_underrun", 32'(underrun0), 32'h0);
      checkOutput("rst_frame_err",32'(frameErr0), 32'h0);
      rst_n = 1'b1;
      waitClk(6);

      // 1: single mode-0 word, tx preloaded
      $display("[TB] Step 1: mode 0 single word");
      nd = ndCnt0; ur = urCnt0; fe = feCnt0;
      writeTx(0, 8'hA5);
      checkOutput("t1_tx_ready_low", 32'(txReady0), 32'h0);
      ssN0 = 1'b0;
      waitClk(HALF);
      checkOutput("t1_busy",    32'(busy0),   32'h1);
      checkOutput("t1_miso_oe", 32'(misoOe0), 32'h1);
      applyStimulus(0, 8'h6C, 8, rx);
      waitClk(HALF);
      ssN0 = 1'b1;
      waitClk(10);
      checkOutput("t1_data_out", 32'(dataOut0), 32'h6C);
      checkOutput("t1_miso_word", 32'(rx), 32'hA5);
      checkOutput("t1_new_data_cnt", 32'(ndCnt0 - nd), 32'd1);
      checkOutput("t1_underrun_cnt", 32'(urCnt0 - ur), 32'd0);
      checkOutput("t1_frame_err_cnt", 32'(feCnt0 - fe), 32'd0);
      checkOutput("t1_idle_busy", 32'(busy0), 32'h0);
      checkOutput("t1_tx_ready_back", 32'(txReady0), 32'h1);

      // 2: back-to-back words, only the first one loaded
      $display("[TB] Step 2: back-to-back words");
      nd = ndCnt0; ur = urCnt0; fe = feCnt0;
      writeTx(0, 8'h3C);
      ssN0 = 1'b0;
      waitClk(HALF);
      applyStimulus(0, 8'h11, 8, rxA);
      checkOutput("t2_data_out_first", 32'(dataOut0), 32'h11);
      applyStimulus(0, 8'h22, 8, rxB);
      waitClk(HALF);
      ssN0 = 1'b1;
      waitClk(10);
      checkOutput("t2_miso_first",  32'(rxA), 32'h3C);
      checkOutput("t2_miso_second", 32'(rxB), 32'h00);
      checkOutput("t2_data_out_second", 32'(dataOut0), 32'h22);
      checkOutput("t2_new_data_cnt", 32'(ndCnt0 - nd), 32'd2);
      checkOutput("t2_underrun_cnt", 32'(urCnt0 - ur), 32'd1);
      checkOutput("t2_frame_err_cnt", 32'(feCnt0 - fe), 32'd0);

      // 3: aborted frame after 5 bits, then a full frame
      $display("[TB] Step 3: aborted frame");
      nd = ndCnt0; fe = feCnt0;
      ssN0 = 1'b0;
      waitClk(HALF);
      applyStimulus(0, 8'hF7, 5, rx);
      waitClk(HALF);
      ssN0 = 1'b1;
      waitClk(10);
      checkOutput("t3_frame_err_cnt", 32'(feCnt0 - fe), 32'd1);
      checkOutput("t3_no_new_data", 32'(ndCnt0 - nd), 32'd0);
      checkOutput("t3_data_out_kept", 32'(dataOut0), 32'h22);
      ssN0 = 1'b0;
      waitClk(HALF);
      applyStimulus(0, 8'h81, 8, rx);
      waitClk(HALF);
      ssN0 = 1'b1;
      waitClk(10);
      checkOutput("t3_data_out", 32'(dataOut0), 32'h81);
      checkOutput("t3_new_data_cnt", 32'(ndCnt0 - nd), 32'd1);
      checkOutput("t3_frame_err_total", 32'(feCnt0 - fe), 32'd1);

      // 4: mode 3 instance
      $display("[TB] Step 4: mode 3 word");
      nd = ndCnt3; ur = urCnt3; fe = feCnt3;
      writeTx(3, 8'hF0);
      ssN3 = 1'b0;
      waitClk(HALF);
      checkOutput("t4_busy", 32'(busy3), 32'h1);
      applyStimulus(3, 8'h0F, 8, rx);
      ssN3 = 1'b1;
      waitClk(10);
      checkOutput("t4_data_out", 32'(dataOut3), 32'h0F);
      checkOutput("t4_miso_word", 32'(rx), 32'hF0);
      checkOutput("t4_new_data_cnt", 32'(ndCnt3 - nd), 32'd1);
      checkOutput("t4_underrun_cnt", 32'(urCnt3 - ur), 32'd0);
      checkOutput("t4_frame_err_cnt", 32'(feCnt3 - fe), 32'd0);

      // 5: second write while holding register is full must be dropped
      $display("[TB] Step 5: holding register full");
      nd = ndCnt0;
      txData0 = 8'h55; txValid0 = 1'b1;
      waitClk(1);
      txData0 = 8'hAA;
      waitClk(1);
      txValid0 = 1'b0;
      checkOutput("t5_tx_ready_low", 32'(txReady0), 32'h0);
      ssN0 = 1'b0;
      waitClk(HALF);
      applyStimulus(0, 8'h00, 8, rx);
      waitClk(HALF);
      ssN0 = 1'b1;
      waitClk(10);
      checkOutput("t5_miso_word", 32'(rx), 32'h55);
      checkOutput("t5_data_out", 32'(dataOut0), 32'h00);
      checkOutput("t5_tx_ready_back", 32'(txReady0), 32'h1);
      checkOutput("t5_new_data_cnt", 32'(ndCnt0 - nd), 32'd1);

      // 6: reset mid-frame, remainder of frame ignored, then a clean frame
      $display("[TB] Step 6: reset mid-frame");
      nd = ndCnt0; fe = feCnt0;
      ssN0 = 1'b0;
      waitClk(HALF);
      applyStimulus(0, 8'h6C, 3, rx);
      rst_n = 1'b0;
      waitClk(2);
      checkOutput("t6_rst_busy",     32'(busy0),    32'h0);
      checkOutput("t6_rst_miso_oe",  32'(misoOe0),  32'h0);
      checkOutput("t6_rst_miso",     32'(miso0),    32'h0);
      checkOutput("t6_rst_data_out", 32'(dataOut0), 32'h0);
      checkOutput("t6_rst_tx_ready", 32'(txReady0), 32'h1);
      rst_n = 1'b1;
      waitClk(2);
      applyStimulus(0, 8'hFF, 5, rx);
      waitClk(4);
      checkOutput("t6_ignored_busy", 32'(busy0), 32'h0);
      checkOutput("t6_no_new_data", 32'(ndCnt0 - nd), 32'd0);
      waitClk(HALF);
      ssN0 = 1'b1;
      waitClk(10);
      checkOutput("t6_no_frame_err", 32'(feCnt0 - fe), 32'd0);
      ssN0 = 1'b0;
      waitClk(HALF);
      applyStimulus(0, 8'h6C, 8, rx);
      waitClk(HALF);
      ssN0 = 1'b1;
      waitClk(10);
      checkOutput("t6_data_out", 32'(dataOut0), 32'h6C);
      checkOutput("t6_new_data_cnt", 32'(ndCnt0 - nd), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
